wash_cycle_sequencer: RTL and testbench
=======================================

// Module: wash_cycle_sequencer
// PURPOSE
//  Sequences the 10-bit seconds countdown timer (`counter`) through a fixed
//  three-phase cycle: FILL, then WASH, then DRAIN.
//  - For each phase it drives the timer's start/seconds inputs and waits for
//    the timer's zero flag.
//  - After the last phase it pulses done once.
//  - Sits between the user controls (start/abort/skip) and a single shared
//    timer instance; runs on the same 1 Hz clock as the timer.
// PARAMETERS
//  FILL_SECONDS   300  phase 0 duration in seconds (10-bit, 0..1023)
//  WASH_SECONDS   420  phase 1 duration in seconds (10-bit, 0..1023)
//  DRAIN_SECONDS  480  phase 2 duration in seconds (10-bit, 0..1023)
// PORTS
//  clk           in   1   system clock (1 Hz), rising-edge
//  reset         in   1   synchronous, active-high; returns block to IDLE
//  start         in   1   level; begins a cycle when sampled high in IDLE
//  abort         in   1   level; cancels the cycle from any state, back to IDLE
//  skip          in   1   level; in RUN, ends the current phase as if timer hit 0
//  tmr_done      in   1   timer zero flag (counter.signal)
//  tmr_start     out  1   one-cycle load pulse to timer (counter.start)
//  tmr_seconds   out  10  duration for current phase (counter.counterSeconds)
//  phase         out  2   0=FILL 1=WASH 2=DRAIN; 0 when not busy
//  busy          out  1   high in LOAD and RUN
//  done          out  1   one-cycle pulse when DRAIN completes
// BEHAVIOUR
//  States: IDLE, LOAD, RUN, DONE (registered).
//  Reset values: state=IDLE, phase=0, tmr_start=0, tmr_seconds=0, busy=0, done=0.
//  Priority each edge: reset > abort > (tmr_done|skip in RUN) > start.
//  Transitions:
//  - IDLE: start=1 -> LOAD with phase=0. start while not IDLE is ignored.
//  - LOAD: tmr_start=1 for exactly this cycle -> RUN. tmr_done is ignored
//    here because it is stale.
//  - RUN: tmr_done=1 or skip=1 ->
//      - phase<2: phase+1 and LOAD.
//      - phase==2: DONE.
//  - DONE: done=1 for this cycle -> IDLE. busy=0. phase=0.
//  - abort in LOAD/RUN/DONE -> IDLE next edge. done is not pulsed. tmr_start
//    is never asserted on the abort edge; the timer is left to run out.
//  tmr_seconds decode (combinational from phase; 0 in IDLE and DONE):
//  - phase 0 = FILL_SECONDS, phase 1 = WASH_SECONDS, phase 2 = DRAIN_SECONDS.
//  - Stable for the whole of LOAD and RUN.
//  Timing: start sampled at edge N gives LOAD in cycle N+1 and RUN from N+2.
//  - Timer loads S at the end of LOAD and reaches 0 on the S-th RUN edge, so
//    tmr_done is seen in the (S+1)-th RUN cycle.
//  - Phase length = S+2 cycles (LOAD + S+1 RUN). S=0 phase = 2 cycles.
//  - start edge to done pulse = F+W+D+6 cycles; done pulse is high in cycle
//    N+F+W+D+7.
//  Boundaries:
//  - start held high through DONE restarts only after IDLE is reached
//    (1 idle cycle minimum).
//  - skip held high advances one phase per LOAD+RUN pair (2 cycles); it is
//    never double-counted.
//  - skip and tmr_done both high count as a single phase end.
//  - start and abort both high in IDLE: stay IDLE.
//  - reset mid-RUN -> IDLE next edge. All outputs take reset values.
//  - phase value 3 is unreachable; decode it to IDLE-safe outputs (seconds=0).
// TESTING  (bench uses a behavioural timer model; FILL=3 WASH=0 DRAIN=2)
//  1. Reset 2 cycles, start pulse at edge 0 -> tmr_start high in cycles 1, 6, 8
//     with seconds 3, 0, 2 -> done high in cycle 12 only -> then IDLE with
//     busy=0.
//  2. Abort in cycle 4 (FILL RUN) -> IDLE in cycle 5. No done pulse. No further
//     tmr_start. phase=0.
//  3. skip held high from cycle 2 -> phases advance every 2 cycles -> done in
//     cycle 7.
//  4. start re-pulsed during RUN -> ignored. Cycle timing identical to test 1.
//  5. reset asserted in cycle 9 (DRAIN) -> cycle 10 shows all outputs 0; start
//     in cycle 11 -> full cycle from phase 0.
//  6. Default params with start held high -> tmr_seconds 300/420/480 in turn;
//     done at cycle 1207; LOAD re-entered at cycle 1209.

Source files
------------

// File: rtl/wash_cycle_sequencer_if.sv
// Control and timer handshake bundle for the wash cycle sequencer.
// master: user controls plus the shared timer side; slave: the sequencer.
interface wash_cycle_sequencer_if;
    logic       start;
    logic       abort;
    logic       skip;
    logic       tmr_done;
    logic       tmr_start;
    logic [9:0] tmr_seconds;
    logic [1:0] phase;
    logic       busy;
    logic       done;

    modport master (
        output start, abort, skip, tmr_done,
        input  tmr_start, tmr_seconds, phase, busy, done
    );

    modport slave (
        input  start, abort, skip, tmr_done,
        output tmr_start, tmr_seconds, phase, busy, done
    );
endinterface

// File: rtl/wash_cycle_sequencer.sv
// Wash cycle sequencer: steps a shared seconds countdown timer through
// FILL, WASH and DRAIN, then pulses done once.
//
//   state | meaning
//   IDLE  | waiting for start; timer untouched
//   LOAD  | one-cycle timer load pulse for the current phase
//   RUN   | waiting for timer zero flag or skip
//   DONE  | one-cycle completion pulse, then back to IDLE
module wash_cycle_sequencer #(
    parameter logic [9:0] FILL_SECONDS  = 10'd300,
    parameter logic [9:0] WASH_SECONDS  = 10'd420,
    parameter logic [9:0] DRAIN_SECONDS = 10'd480
) (
    input logic                    clk,
    input logic                    reset,
    wash_cycle_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] phase_q;
    logic [1:0] phase_next;

    logic       tmr_start_c;
    logic [9:0] tmr_seconds_c;
    logic [1:0] phase_c;
    logic       busy_c;
    logic       done_c;

    // State and phase registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            phase_q <= 2'd0;
        end else begin
            state   <= state_next;
            phase_q <= phase_next;
        end
    end

    // Next-state logic and output decode.
    always_comb begin
        state_next    = state;
        phase_next    = phase_q;
        tmr_start_c   = 1'b0;
        tmr_seconds_c = 10'd0;
        phase_c       = 2'd0;
        busy_c        = 1'b0;
        done_c        = 1'b0;

        case (state)
            IDLE: begin
                phase_next = 2'd0;
                if (!bus.abort && bus.start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                busy_c = 1'b1;
                // An aborting cycle must not reload the timer.
                tmr_start_c = !bus.abort;
                if (bus.abort) begin
                    state_next = IDLE;
                    phase_next = 2'd0;
                end else begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy_c = 1'b1;
                if (bus.abort) begin
                    state_next = IDLE;
                    phase_next = 2'd0;
                end else if (bus.tmr_done || bus.skip) begin
                    if (phase_q < 2'd2) begin
                        phase_next = phase_q + 2'd1;
                        state_next = LOAD;
                    end else begin
                        phase_next = 2'd0;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                done_c     = !bus.abort;
                state_next = IDLE;
                phase_next = 2'd0;
            end
            default: begin
                state_next = IDLE;
                phase_next = 2'd0;
            end
        endcase

        // Phase and duration are only meaningful while busy; phase 3 is
        // unreachable and decodes to a zero duration.
        if (busy_c) begin
            phase_c = phase_q;
            case (phase_q)
                2'd0:    tmr_seconds_c = FILL_SECONDS;
                2'd1:    tmr_seconds_c = WASH_SECONDS;
                2'd2:    tmr_seconds_c = DRAIN_SECONDS;
                default: tmr_seconds_c = 10'd0;
            endcase
        end
    end

    assign bus.tmr_start   = tmr_start_c;
    assign bus.tmr_seconds = tmr_seconds_c;
    assign bus.phase       = phase_c;
    assign bus.busy        = busy_c;
    assign bus.done        = done_c;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Bench for wash_cycle_sequencer: behavioural timers, a phase-level
// reference model, directed scenarios, randomized controls, and a
// default-parameter long run on a second instance.
module tb_wash_cycle_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    wash_cycle_sequencer_if bus ();
    wash_cycle_sequencer_if bus2 ();

    wash_cycle_sequencer #(
        .FILL_SECONDS (10'd3),
        .WASH_SECONDS (10'd0),
        .DRAIN_SECONDS(10'd2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    wash_cycle_sequencer dut2 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus2)
    );

    // Behavioural seconds timers: load on start, count down to zero, hold.
    logic [9:0] tcnt  = 10'd0;
    logic [9:0] tcnt2 = 10'd0;
    always @(posedge clk) begin
        if (bus.tmr_start) tcnt <= bus.tmr_seconds;
        else if (tcnt != 10'd0) tcnt <= tcnt - 10'd1;
        if (bus2.tmr_start) tcnt2 <= bus2.tmr_seconds;
        else if (tcnt2 != 10'd0) tcnt2 <= tcnt2 - 10'd1;
    end
    assign bus.tmr_done  = (tcnt == 10'd0);
    assign bus2.tmr_done = (tcnt2 == 10'd0);

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int st_cyc[$], st_sec[$], dn_cyc[$];
    int st2_cyc[$], st2_sec[$], dn2_cyc[$];

    // Reference model: active cycle, current phase index, whether this
    // cycle is the timer-load cycle, whether this cycle is the completion.
    bit m_active = 0;
    bit m_load = 0;
    bit m_fin = 0;
    int m_ph = 0;

    function automatic int phase_secs(int p);
        int s [3] = '{3, 0, 2};
        return s[p];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_q(input string tag, input int q[$], input int e[$]);
        chk({tag, "_count"}, q.size(), e.size());
        for (int i = 0; i < q.size() && i < e.size(); i++)
            chk(tag, q[i], e[i]);
    endtask

    // One clock cycle: drive controls, check at mid-cycle, advance model.
    task automatic cycle(input bit st, input bit ab, input bit sk, input bit rs);
        logic [14:0] exp_v, obs_v;
        bit ex_start, ex_done;
        int ex_ph, ex_sec;
        bit td;
        bus.start = st;
        bus.abort = ab;
        bus.skip  = sk;
        reset     = rs;
        @(negedge clk);
        ex_start = m_active && m_load && !ab;
        ex_done  = m_fin && !ab;
        ex_ph    = m_active ? m_ph : 0;
        ex_sec   = m_active ? phase_secs(m_ph) : 0;
        exp_v = {ex_start, ex_sec[9:0], ex_ph[1:0], m_active, ex_done};
        obs_v = {bus.tmr_start, bus.tmr_seconds, bus.phase, bus.busy, bus.done};
        chk("outs", {17'd0, obs_v}, {17'd0, exp_v});
        if (bus.tmr_start) begin st_cyc.push_back(cyc); st_sec.push_back(int'(bus.tmr_seconds)); end
        if (bus.done) dn_cyc.push_back(cyc);
        if (bus2.tmr_start) begin st2_cyc.push_back(cyc); st2_sec.push_back(int'(bus2.tmr_seconds)); end
        if (bus2.done) dn2_cyc.push_back(cyc);
        td = bus.tmr_done;
        if (rs || ab || m_fin) begin
            m_active = 0; m_load = 0; m_fin = 0; m_ph = 0;
        end else if (!m_active) begin
            if (st) begin m_active = 1; m_load = 1; m_ph = 0; end
        end else if (m_load) begin
            m_load = 0;
        end else if (td || sk) begin
            if (m_ph < 2) begin m_ph++; m_load = 1; end
            else begin m_active = 0; m_fin = 1; m_ph = 0; end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic begin_test();
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        cyc = 0;
        st_cyc.delete(); st_sec.delete(); dn_cyc.delete();
        st2_cyc.delete(); st2_sec.delete(); dn2_cyc.delete();
    endtask

    initial begin
        int e1[$], e2[$], e3[$];
        bus.start = 0; bus.abort = 0; bus.skip = 0;
        bus2.start = 0; bus2.abort = 0; bus2.skip = 0;
        @(posedge clk); #1;

        // Reset state and a plain full cycle.
        begin_test();
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_phase", bus.phase, 2'd0);
        for (int i = 0; i < 16; i++) cycle(i == 0, 0, 0, 0);
        e1 = '{1, 6, 8}; e2 = '{3, 0, 2}; e3 = '{12};
        chk_q("t1_start", st_cyc, e1);
        chk_q("t1_secs", st_sec, e2);
        chk_q("t1_done", dn_cyc, e3);
        chk("t1_idle_busy", bus.busy, 1'b0);

        // Abort during FILL run.
        begin_test();
        for (int i = 0; i < 12; i++) cycle(i == 0, i == 4, 0, 0);
        e1 = '{1}; e3 = {};
        chk_q("t2_start", st_cyc, e1);
        chk_q("t2_done", dn_cyc, e3);
        chk("t2_phase", bus.phase, 2'd0);

        // Skip held high advances a phase every two cycles.
        begin_test();
        for (int i = 0; i < 12; i++) cycle(i == 0, 0, i >= 2 && i <= 9, 0);
        e1 = '{1, 3, 5}; e3 = '{7};
        chk_q("t3_start", st_cyc, e1);
        chk_q("t3_done", dn_cyc, e3);

        // Start re-pulsed while running is ignored.
        begin_test();
        for (int i = 0; i < 16; i++) cycle(i == 0 || i == 3 || i == 9, 0, 0, 0);
        e1 = '{1, 6, 8}; e3 = '{12};
        chk_q("t4_start", st_cyc, e1);
        chk_q("t4_done", dn_cyc, e3);

        // Reset during DRAIN, then a fresh cycle.
        begin_test();
        for (int i = 0; i < 27; i++) cycle(i == 0 || i == 11, 0, 0, i == 9);
        e1 = '{1, 6, 8, 12, 17, 19}; e3 = '{23};
        chk_q("t5_start", st_cyc, e1);
        chk_q("t5_done", dn_cyc, e3);

        // Start and abort together in IDLE.
        begin_test();
        for (int i = 0; i < 4; i++) cycle(i == 0, i == 0, 0, 0);
        e3 = {};
        chk_q("t5b_start", st_cyc, e3);

        // Randomized controls against the model.
        begin_test();
        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 60) == 0);

        // Default durations with start held high on the second instance.
        begin_test();
        bus2.start = 1;
        for (int i = 0; i < 1212; i++) cycle(0, 0, 0, 0);
        bus2.start = 0;
        e1 = '{1, 303, 725, 1209}; e2 = '{300, 420, 480, 300}; e3 = '{1207};
        chk_q("t6_start", st2_cyc, e1);
        chk_q("t6_secs", st2_sec, e2);
        chk_q("t6_done", dn2_cyc, e3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
